// File: rtl/start_pulse_responder.sv
// start_pulse_responder
//   Responder side of the start / a&&b handshake. A 0->1 transition on
//   start, seen between two consecutive posedge samples, launches one
//   response: after DELAY edges a and b go high together for HOLD edges.
//   Busy state, a saturating completed-response count and a sticky
//   overrun flag are kept alongside.
//
//   Optional: define RSP_SVA_EN to compile the embedded concurrent
//   assertions (P1..P4). Without it no assertion code is built and the
//   behaviour is identical.
//
// Parameters
//   DELAY  cycles from the edge sampling the start rise to the first edge
//          sampling a&&b high (1..15)
//   HOLD   number of consecutive sampling edges with a&&b high (1..15)
//   CNT_W  width of the completed-response counter
//
// Ports
//   clk       single clock, posedge
//   rst       asynchronous active-high reset
//   start     request; only a rising transition is acted on
//   a, b      response pair, registered, always equal
//   busy      high while a response is pending or being driven
//   resp_cnt  completed responses, saturating
//   overrun   sticky: a rise arrived while busy
module start_pulse_responder #(
  parameter int DELAY = 1,
  parameter int HOLD  = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a,
  output logic             b,
  output logic             busy,
  output logic [CNT_W-1:0] resp_cnt,
  output logic             overrun
);

  typedef enum logic [1:0] {IDLE, WAIT, DRIVE} state_e;

  // WAIT spends DELAY-1 edges counting down, DRIVE spends HOLD edges;
  // both counters terminate on zero, hence the -1 / -2 load values.
  localparam logic [3:0] WAIT_LD = (DELAY > 1) ? 4'(DELAY - 2) : 4'd0;
  localparam logic [3:0] HOLD_LD = 4'(HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           state_q;
  logic [3:0]       cnt_q;
  logic             start_q;
  logic             a_q;
  logic             busy_q;
  logic             ovr_q;
  logic [CNT_W-1:0] rcnt_q;

  logic rise;
  logic last_drive;
  logic accept;

  assign rise       = start & ~start_q;
  assign last_drive = (state_q == DRIVE) && (cnt_q == 4'd0);
  // A rise is taken as a new request in IDLE and on the DRIVE exit edge;
  // anywhere else while busy it only flags overrun.
  assign accept     = rise && ((state_q == IDLE) || last_drive);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      start_q <= 1'b0;
      a_q     <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
      rcnt_q  <= '0;
    end else begin
      start_q <= start;
      case (state_q)
        IDLE: begin
          if (accept) begin
            busy_q <= 1'b1;
            if (DELAY == 1) begin
              state_q <= DRIVE;
              a_q     <= 1'b1;
              cnt_q   <= HOLD_LD;
            end else begin
              state_q <= WAIT;
              a_q     <= 1'b0;
              cnt_q   <= WAIT_LD;
            end
          end
        end
        WAIT: begin
          if (rise) ovr_q <= 1'b1;
          if (cnt_q == 4'd0) begin
            state_q <= DRIVE;
            a_q     <= 1'b1;
            cnt_q   <= HOLD_LD;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DRIVE: begin
          if (cnt_q == 4'd0) begin
            if (rcnt_q != CNT_MAX) rcnt_q <= rcnt_q + 1'b1;
            if (accept) begin
              // back-to-back: relaunch without passing through IDLE
              busy_q <= 1'b1;
              if (DELAY == 1) begin
                state_q <= DRIVE;
                a_q     <= 1'b1;
                cnt_q   <= HOLD_LD;
              end else begin
                state_q <= WAIT;
                a_q     <= 1'b0;
                cnt_q   <= WAIT_LD;
              end
            end else begin
              state_q <= IDLE;
              a_q     <= 1'b0;
              busy_q  <= 1'b0;
            end
          end else begin
            if (rise) ovr_q <= 1'b1;
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          a_q     <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // a and b come from one flop so they can never differ.
  assign a        = a_q;
  assign b        = a_q;
  assign busy     = busy_q;
  assign resp_cnt = rcnt_q;
  assign overrun  = ovr_q;

`ifdef RSP_SVA_EN
  let both_hi(x, y) = x && y;

  // The trailing term tolerates a staying high when the exit edge itself
  // accepted a new request (DELAY=1 back-to-back).
  p1_resp: assert property (@(posedge clk) disable iff (rst)
    accept |-> ##DELAY both_hi(a, b) [*HOLD] ##1 (!a || $past(accept)))
    $info("P1 ok at %0t", $time);
  else
    $error("P1 violated at %0t", $time);

  p2_eq: assert property (@(posedge clk) disable iff (rst) a == b)
    $info("P2 ok at %0t", $time);
  else
    $error("P2 violated at %0t", $time);

  p3_ovr: assert property (@(posedge clk) disable iff (rst)
    busy && rise && !last_drive |=> overrun)
    $info("P3 ok at %0t", $time);
  else
    $error("P3 violated at %0t", $time);

  p4_ovr_busy: assert property (@(posedge clk) disable iff (rst)
    $rose(overrun) |-> $past(busy))
    $info("P4 ok at %0t", $time);
  else
    $error("P4 violated at %0t", $time);
`endif

endmodule

// File: tb/tb_start_pulse_responder.sv
// Bench for start_pulse_responder: four instances with different
// parameter sets share one clock. A vector table drives one instance per
// row (start sampled at the next posedge, outputs compared #1 after it);
// hand-written sequences cover async reset mid-response, a rise on the
// first edge after reset, and counter saturation.
module tb_start_pulse_responder;

  logic       clk;
  logic [3:0] rst_v, st, av, bv, bz, ov;
  logic [7:0] rc0, rc1, rc2;
  logic [1:0] rc3;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int dut;
    bit rst;
    bit start;
    bit ea;
    bit ebusy;
    int ecnt;
    bit eovr;
  } vec_t;

  vec_t tbl[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // u0 defaults, u1 DELAY=3/HOLD=2, u2 DELAY=2/HOLD=4, u3 CNT_W=2
  start_pulse_responder u0 (.clk(clk), .rst(rst_v[0]), .start(st[0]), .a(av[0]), .b(bv[0]),
                            .busy(bz[0]), .resp_cnt(rc0), .overrun(ov[0]));
  start_pulse_responder #(.DELAY(3), .HOLD(2)) u1 (.clk(clk), .rst(rst_v[1]), .start(st[1]),
                            .a(av[1]), .b(bv[1]), .busy(bz[1]), .resp_cnt(rc1), .overrun(ov[1]));
  start_pulse_responder #(.DELAY(2), .HOLD(4)) u2 (.clk(clk), .rst(rst_v[2]), .start(st[2]),
                            .a(av[2]), .b(bv[2]), .busy(bz[2]), .resp_cnt(rc2), .overrun(ov[2]));
  start_pulse_responder #(.CNT_W(2)) u3 (.clk(clk), .rst(rst_v[3]), .start(st[3]), .a(av[3]),
                            .b(bv[3]), .busy(bz[3]), .resp_cnt(rc3), .overrun(ov[3]));

  function automatic int rc(int d);
    case (d)
      0:       return int'(rc0);
      1:       return int'(rc1);
      2:       return int'(rc2);
      default: return int'(rc3);
    endcase
  endfunction

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(string nm, int d, bit ea, bit ebusy, int ecnt, bit eovr);
    chk({nm, "_a"},    int'(av[d]), int'(ea));
    chk({nm, "_b"},    int'(bv[d]), int'(ea));
    chk({nm, "_busy"}, int'(bz[d]), int'(ebusy));
    chk({nm, "_cnt"},  rc(d),       ecnt);
    chk({nm, "_ovr"},  int'(ov[d]), int'(eovr));
  endtask

  task automatic add(int d, bit r, bit s, bit ea, bit ebusy, int ecnt, bit eovr);
    vec_t v;
    v.dut = d; v.rst = r; v.start = s; v.ea = ea; v.ebusy = ebusy; v.ecnt = ecnt; v.eovr = eovr;
    tbl.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // u0: single pulse, then start held high 20 cycles, low 1, high again
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 1, 1, 1, 1, 0);
    for (int i = 0; i < 19; i++) add(0, 0, 1, 0, 0, 2, 0);
    add(0, 0, 0, 0, 0, 2, 0);
    add(0, 0, 1, 1, 1, 2, 0);
    add(0, 0, 0, 0, 0, 3, 0);
    // u1: rise, second rise while in WAIT -> ignored, overrun sticky
    add(1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 1, 0, 1, 0, 0);
    add(1, 0, 0, 0, 1, 0, 0);
    add(1, 0, 1, 1, 1, 0, 1);
    add(1, 0, 0, 1, 1, 0, 1);
    add(1, 0, 0, 0, 0, 1, 1);
    add(1, 0, 0, 0, 0, 1, 1);
    // u2: response, rise on the DRIVE exit edge accepted, second response
    add(2, 0, 1, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) add(2, 0, 0, 1, 1, 0, 0);
    add(2, 0, 1, 0, 1, 1, 0);
    for (int i = 0; i < 4; i++) add(2, 0, 0, 1, 1, 1, 0);
    add(2, 0, 0, 0, 0, 2, 0);

    rst_v = 4'hF;
    st    = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++) chk_all($sformatf("reset_u%0d", d), d, 0, 0, 0, 0);
    rst_v = 4'h0;

    foreach (tbl[i]) begin
      rst_v[tbl[i].dut] = tbl[i].rst;
      st[tbl[i].dut]    = tbl[i].start;
      tick();
      chk_all($sformatf("row%0d", i), tbl[i].dut, tbl[i].ea, tbl[i].ebusy, tbl[i].ecnt, tbl[i].eovr);
    end

    // u2: async reset while driving drops a/b without a clock edge
    st[2] = 1'b1; tick();
    st[2] = 1'b0; tick();
    tick();
    chk_all("pre_rst", 2, 1, 1, 2, 0);
    #2;
    rst_v[2] = 1'b1;
    #1;
    chk_all("async_rst", 2, 0, 0, 0, 0);
    tick();
    rst_v[2] = 1'b0;
    st[2] = 1'b1; tick();
    chk_all("post_rst_wait", 2, 0, 1, 0, 0);
    st[2] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_all($sformatf("post_rst_drv%0d", i), 2, 1, 1, 0, 0);
    end
    tick();
    chk_all("post_rst_done", 2, 0, 0, 1, 0);

    // u0: start already high at the first edge after reset release
    rst_v[0] = 1'b1; st[0] = 1'b1; tick();
    chk_all("first_edge_rst", 0, 0, 0, 0, 0);
    rst_v[0] = 1'b0; tick();
    chk_all("first_edge_rise", 0, 1, 1, 0, 0);
    st[0] = 1'b0; tick();
    chk_all("first_edge_done", 0, 0, 0, 1, 0);

    // u3: 2-bit counter saturates at 3
    for (int i = 0; i < 5; i++) begin
      st[3] = 1'b1; tick();
      chk($sformatf("sat%0d_a", i), int'(av[3]), 1);
      st[3] = 1'b0; tick();
      chk($sformatf("sat%0d_cnt", i), rc(3), (i + 1 > 3) ? 3 : i + 1);
      tick();
    end
    chk("sat_ovr", int'(ov[3]), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/start_pulse_responder.md
Name: start_pulse_responder

Overview:
- Responder end of the start / a&&b handshake used by the team's SVA checks.
- Detects a rising edge on start and drives the response pair a and b high together.
  - Response begins a fixed delay after the rise and lasts a fixed number of cycles.
- Tracks busy state, completed-response count and a sticky overrun flag.
- Sits as the DUT behind the existing $rose(start) |-> ##1 (a&&b) property checks.

Parameters:
- DELAY, 1, cycles from the edge sampling the start rise to the first edge sampling a&&b high; legal range 1..15.
- HOLD, 1, number of consecutive sampling edges on which a&&b is high; legal range 1..15.
- CNT_W, 8, width of the completed-response counter.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; only a 0->1 transition between consecutive posedge samples is acted on.
- a  output  1  response bit, registered.
- b  output  1  response bit, registered; always equal to a.
- busy  output  1  high while a response is pending or being driven.
- resp_cnt  output  CNT_W  number of completed responses; saturating.
- overrun  output  1  sticky; a start rise occurred while busy.

Behaviour:
- Reset (async, rst=1): a=0, b=0, busy=0, resp_cnt=0, overrun=0, internal start_q=0, FSM=IDLE.
- Rise detect: rise = start & ~start_q, evaluated at each posedge; start_q <= start every edge.
  - Because start_q resets to 0, start already high at the first edge after reset release counts as a rise.
- Latency, rise sampled at edge k:
  - a=b=1 as sampled at edges k+DELAY through k+DELAY+HOLD-1.
  - a=b=0 as sampled at edge k+DELAY+HOLD.
  - With DELAY=1 the registers are set by edge k itself.
- FSM states: IDLE, WAIT, DRIVE.
  - IDLE + rise: go to DRIVE (DELAY=1) or WAIT (DELAY>1); load the down-counter.
  - WAIT: counts down DELAY-1 edges, then enters DRIVE with a=b set.
  - DRIVE: holds a=b=1 for HOLD edges. On the last edge it clears a/b, returns to IDLE and increments resp_cnt.
- busy=1 in WAIT and DRIVE (registered with the state); 0 in IDLE.
- Rise while busy (WAIT/DRIVE, excluding the DRIVE exit edge):
  - The rise is ignored.
  - overrun <= 1, held until reset.
  - The current response is unaffected.
- Rise on the DRIVE exit edge: accepted as a new request, no overrun.
  - resp_cnt still increments.
  - With DELAY=1, a/b stay continuously high across both responses.
- resp_cnt saturates at 2^CNT_W-1; no wrap.
- start held high for many cycles produces exactly one response; it must return low before another rise counts.
- Reset asserted mid-WAIT/DRIVE:
  - a/b drop immediately (async).
  - The response is abandoned; no count increment.
- a and b are never different on any cycle.

Optional Feature:
- Macro: RSP_SVA_EN.
- Defined: the module embeds concurrent assertions clocked on posedge clk, all disabled iff rst. They are built from let declarations, e.g. let both_hi(x,y)=x&&y.
  - P1: rise |-> ##DELAY both_hi(a,b)[*HOLD] ##1 !a, excluding the back-to-back case.
  - P2: a==b always.
  - P3: busy && rise && !exit |=> overrun.
  - P4: $rose(overrun) only while busy.
  - Each pass reports via $info with $time; each fail reports via $error.
- Undefined: no assertion code is compiled; RTL behaviour is identical.

Test Plan:
- Defaults, start low 3 cycles, 1-cycle pulse rising at edge k -> a=b=1 sampled at k+1 only, 0 at k+2; resp_cnt=1; busy high for 1 cycle; overrun=0.
- DELAY=3, HOLD=2, start rise at edge 10 -> a=b=1 at edges 13,14; 0 at 15; busy sampled 1 at edges 11-14; resp_cnt=1.
- DELAY=3, HOLD=2, second rise at edge 12 (in WAIT) -> ignored; overrun=1 from edge 13 and stays 1; exactly one response; resp_cnt=1.
- Defaults, start held high 20 cycles -> exactly one 1-cycle response; resp_cnt=1. Then start low 1 cycle and high again -> second response; resp_cnt=2.
- DELAY=2, HOLD=4, rst pulsed while in DRIVE -> a=b=0 immediately; resp_cnt unchanged at 0; overrun=0; next rise yields a normal response.
- CNT_W=2, 5 separated pulses -> resp_cnt reads 1,2,3,3,3 (saturates); with RSP_SVA_EN defined, zero assertion failures.
